dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder (slave end) for the pipelined RV32 core's load/store port.
- Accepts one request at a time over a valid/ready handshake and performs byte/half/word accesses with RISC-V funct3 sizing.
- Applies a programmable number of wait states, then returns read data or an error with a one-cycle response pulse.
- Sits between the core's MEM stage and the data-RAM storage; it replaces the single-cycle RAM when memory latency must be modelled.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; the byte address range is 0 .. DEPTH_WORDS*4-1.
- WAIT_CYCLES, 2: wait states between accept and access (0..15).
- CNT_W, 4: width of the wait counter; must satisfy WAIT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_ubhw  in  3  RISC-V funct3 size code.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal size; valid only with resp_valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - Storage array is NOT cleared.
  - A pending request is dropped; a store not yet at its access edge never writes.
- State IDLE:
  - req_ready=1.
  - req_valid=1 at an edge accepts the request: capture we/addr/wdata/ubhw, load counter=WAIT_CYCLES, go to BUSY.
- State BUSY:
  - req_ready=0.
  - If counter != 0: decrement.
  - If counter == 0: perform the access on this edge and go to RESP.
- State RESP:
  - resp_valid=1 for exactly one cycle, req_ready=0, then go to IDLE.
  - resp_rdata and resp_err hold their values until the next access edge.
- Latency: the accept edge is edge 0; resp_valid is high in the cycle after edge WAIT_CYCLES+1. Throughput is one request per WAIT_CYCLES+3 cycles.
- Size codes:
  - 000 = B, sign-extended.
  - 001 = H, sign-extended.
  - 010 = W.
  - 100 = BU, zero-extended.
  - 101 = HU, zero-extended.
  - 011, 110, 111 are illegal and give err.
- Alignment: H/HU require addr[0]=0; W requires addr[1:0]=0. A violation gives err.
- Range: addr >= DEPTH_WORDS*4 gives err.
- On err: no write occurs and resp_rdata=0.
- Storage is little-endian. Word index is addr[31:2] (range-checked). Byte lane is addr[1:0]; half lane is addr[1].
- Store: write only the addressed lanes using a byte mask from size and addr[1:0]; other bytes are unchanged.
- Load: select the lane, shift to bit 0, then sign- or zero-extend.
- Ordering: the access is atomic on the access edge, so a later read returns data from a preceding write (no stale data).
- req_valid while not in IDLE is ignored; the requester must hold the request until req_ready=1.

Decomposition:
- Shared package (dmem_pkg):
  - funct3 size constants SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101.
  - State encoding IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
- Sub-module mem_lane_align (combinational), used by the top FSM/storage:
  - Inputs: ubhw, addr[1:0], wdata, raw read word.
  - Outputs: byte mask[3:0], lane-shifted write word, extended read data, misalign flag.

Test Plan:
- Reset mid-operation: WAIT_CYCLES=2; SW 0x0000_0040 := 0x1234_5678, assert rst at edge 1 after accept, release, then LW 0x40 → that word is unchanged (not 0x1234_5678), and resp_valid=0 during reset.
- Latency: WAIT_CYCLES=2; SW 0x40 := 0xDEADBEEF accepted at edge 0 → resp_valid only in the cycle after edge 3, resp_err=0, req_ready=0 until IDLE. Then LW 0x40 → 0xDEADBEEF.
- Byte/half lanes: SB 0x41 := 0x0000_0080 over word 0xDEADBEEF → word 0xDEAD80EF. LB 0x41 → 0xFFFF_FF80; LBU 0x41 → 0x0000_0080; LH 0x42 → 0xFFFF_DEAD; LHU 0x42 → 0x0000_DEAD.
- Errors: LH 0x43 → resp_err=1, rdata=0. SW 0x42 → err and memory unchanged. LW DEPTH_WORDS*4 → err. ubhw=3'b011 → err.
- Handshake: req_valid held high with a new address during BUSY → ignored; that request is accepted only in the next IDLE cycle, giving exactly one resp_valid per accepted request.
- WAIT_CYCLES=0: SW 0x0 := 0x1 then LW 0x0 → each resp_valid follows its accept edge by 1 cycle and returns 0x0000_0001.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder:
// RISC-V funct3 size codes, FSM state encoding and a size-legality helper.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic size_legal(input logic [2:0] ubhw);
    case (ubhw)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core's MEM stage (master) and the responder (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ubhw;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_ubhw,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_ubhw,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_responder_mem_lane_align.sv
// Byte-lane steering for one access: write mask and replicated store data,
// load-lane extraction with sign/zero extension, and the alignment check.
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_ubhw,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_raw,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_sh,
  output logic [31:0] o_rdata_ext,
  output logic        o_misalign
);

  logic [31:0] w_lane;

  assign w_lane = i_rdata_raw >> {i_addr_lo, 3'b000};

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_be        = '0;
    o_wdata_sh  = '0;
    o_rdata_ext = '0;
    o_misalign  = 1'b0;
    case (i_ubhw)
      SZ_B, SZ_BU: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata_sh  = {4{i_wdata[7:0]}};
        o_rdata_ext = {{24{w_lane[7] & ~i_ubhw[2]}}, w_lane[7:0]};
      end
      SZ_H, SZ_HU: begin
        o_misalign  = i_addr_lo[0];
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_sh  = {2{i_wdata[15:0]}};
        o_rdata_ext = {{16{w_lane[15] & ~i_ubhw[2]}}, w_lane[15:0]};
      end
      SZ_W: begin
        o_misalign  = |i_addr_lo;
        o_be        = 4'b1111;
        o_wdata_sh  = i_wdata;
        o_rdata_ext = w_lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, performs the
// access atomically on a single edge and returns a one-cycle response pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [2:0]         r_ubhw;
  logic               r_ready;
  logic               r_resp_valid;
  logic [31:0]        r_resp_rdata;
  logic               r_resp_err;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0]   w_idx;
  logic [31:0]        w_raw;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_sh;
  logic [31:0]        w_rdata_ext;
  logic               w_misalign;
  logic               w_err;
  logic               w_access;
  logic               w_wr_en;

  assign w_idx    = r_addr[IDX_W+1:2];
  assign w_raw    = r_mem[w_idx];
  assign w_err    = ~size_legal(r_ubhw) | w_misalign | (r_addr >= LIMIT);
  assign w_access = (r_state == BUSY) && (r_cnt == '0);
  assign w_wr_en  = w_access & r_we & ~w_err;

  mem_lane_align u_align (
    .i_ubhw      (r_ubhw),
    .i_addr_lo   (r_addr[1:0]),
    .i_wdata     (r_wdata),
    .i_rdata_raw (w_raw),
    .o_be        (w_be),
    .o_wdata_sh  (w_wdata_sh),
    .o_rdata_ext (w_rdata_ext),
    .o_misalign  (w_misalign)
  );

  // NOTE: sequential state is updated with <= so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ubhw       <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_ubhw  <= bus.req_ubhw;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_ready <= 1'b0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_resp_rdata <= (w_err || r_we) ? '0 : w_rdata_ext;
            r_state      <= RESP;
          end
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset; it maps onto RAM and keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule
